// File: rtl/pl2ddr_write_scheduler.sv
// Round-robin scheduler feeding producer bursts to the PL-to-DDR AXI write master.
// Destination addresses walk a circular DDR region; error and timeout status are sticky.
//   state | meaning
//   IDLE  | waiting for a request or applying a clear
//   ARB   | round-robin selection, grant registered
//   START | INIT_AXI_TXN pulse to the master
//   WAIT  | waiting for TXN_DONE, timeout timer running
//   DONE  | ack the producer, advance the ring address
//   HALT  | timed out, waiting for CLEAR
module pl2ddr_write_scheduler #(
  parameter int                    NUM_REQ        = 4,
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] REGION_BYTES   = 32'h0010_0000,
  parameter int                    BURST_BYTES    = 1024,
  parameter int                    TIMEOUT_CYCLES = 65535
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       ENABLE,
  input  logic                       CLEAR,
  input  logic [NUM_REQ-1:0]         REQ,
  output logic [NUM_REQ-1:0]         GRANT,
  output logic [$clog2(NUM_REQ)-1:0] GRANT_ID,
  output logic [NUM_REQ-1:0]         DONE_ACK,
  output logic [ADDR_WIDTH-1:0]      TXN_ADDR,
  output logic                       INIT_AXI_TXN,
  input  logic                       TXN_DONE,
  input  logic                       TXN_ERROR,
  output logic                       BUSY,
  output logic                       ERR_FLAG,
  output logic                       TIMEOUT_ERR,
  output logic [15:0]                WRAP_COUNT
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] RING_END = BASE_ADDR + REGION_BYTES;
  localparam logic [ADDR_WIDTH-1:0] BURST    = ADDR_WIDTH'(BURST_BYTES);
  localparam logic [TO_W-1:0]       TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_START, S_WAIT, S_DONE, S_HALT} state_t;
  state_t state, state_nxt;

  logic [ID_W-1:0]       rr, arb_id;
  logic [ID_W:0]         idx;
  logic                  arb_found, pend_clr, clr_now;
  logic [TO_W-1:0]       tmr;
  logic [ADDR_WIDTH-1:0] addr_inc;

  assign clr_now  = (state == S_IDLE && (pend_clr || CLEAR)) || (state == S_HALT && CLEAR);
  assign addr_inc = TXN_ADDR + BURST;

  // Walk downward so the lowest offset from rr is the last one written and wins.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    idx       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr} + (ID_W + 1)'(i);
      if (idx >= (ID_W + 1)'(NUM_REQ)) idx = idx - (ID_W + 1)'(NUM_REQ);
      if (REQ[idx[ID_W-1:0]]) begin
        arb_found = 1'b1;
        arb_id    = idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!(pend_clr || CLEAR) && ENABLE && |REQ) state_nxt = S_ARB;
      S_ARB:   state_nxt = arb_found ? S_START : S_IDLE;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (TXN_DONE) state_nxt = S_DONE;
               else if (tmr == '0) state_nxt = S_HALT;
      S_DONE:  state_nxt = S_IDLE;
      S_HALT:  if (CLEAR) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY         = (state != S_IDLE);
    INIT_AXI_TXN = (state == S_START);
    DONE_ACK     = (state == S_DONE) ? (NUM_REQ'(1) << GRANT_ID) : '0;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      GRANT       <= '0;
      GRANT_ID    <= '0;
      TXN_ADDR    <= BASE_ADDR;
      ERR_FLAG    <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      WRAP_COUNT  <= '0;
      rr          <= '0;
      pend_clr    <= 1'b0;
      tmr         <= TO_LOAD;
    end else begin
      if (clr_now) begin
        TXN_ADDR    <= BASE_ADDR;
        WRAP_COUNT  <= '0;
        ERR_FLAG    <= 1'b0;
        TIMEOUT_ERR <= 1'b0;
        rr          <= '0;
        pend_clr    <= 1'b0;
      end else if (CLEAR && state inside {S_ARB, S_START, S_WAIT, S_DONE}) begin
        pend_clr <= 1'b1;
      end
      case (state)
        S_ARB: if (arb_found) begin
          GRANT    <= NUM_REQ'(1) << arb_id;
          GRANT_ID <= arb_id;
        end
        S_START: tmr <= TO_LOAD;
        S_WAIT: begin
          if (TXN_DONE) begin
            if (TXN_ERROR) ERR_FLAG <= 1'b1;
          end else if (tmr == '0) begin
            TIMEOUT_ERR <= 1'b1;
            GRANT       <= '0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_DONE: begin
          GRANT <= '0;
          rr    <= (GRANT_ID == ID_W'(NUM_REQ - 1)) ? '0 : GRANT_ID + 1'b1;
          if (addr_inc == RING_END) begin
            TXN_ADDR <= BASE_ADDR;
            if (WRAP_COUNT != 16'hFFFF) WRAP_COUNT <= WRAP_COUNT + 1'b1;
          end else begin
            TXN_ADDR <= addr_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pl2ddr_write_scheduler.sv
// Bench for pl2ddr_write_scheduler: directed scenarios plus random bursts checked
// against a burst-count model of the ring, round-robin pointer and sticky flags.
module tb_pl2ddr_write_scheduler;
  localparam int          N           = 4;
  localparam logic [31:0] BASE        = 32'h1000_0000;
  localparam int          BURST       = 1024;
  localparam int          RING_BURSTS = 4;
  localparam int          TO          = 20;

  logic        ACLK = 1'b0;
  logic        ARESET, ENABLE, CLEAR, TXN_DONE, TXN_ERROR;
  logic [N-1:0] REQ, GRANT, DONE_ACK;
  logic [1:0]  GRANT_ID;
  logic [31:0] TXN_ADDR;
  logic        INIT_AXI_TXN, BUSY, ERR_FLAG, TIMEOUT_ERR;
  logic [15:0] WRAP_COUNT;

  int checks = 0;
  int failures = 0;
  int m_bursts, m_rr;
  bit m_err;

  pl2ddr_write_scheduler #(
    .NUM_REQ(N), .ADDR_WIDTH(32), .BASE_ADDR(BASE), .REGION_BYTES(32'h0000_1000),
    .BURST_BYTES(BURST), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .ENABLE(ENABLE), .CLEAR(CLEAR), .REQ(REQ),
    .GRANT(GRANT), .GRANT_ID(GRANT_ID), .DONE_ACK(DONE_ACK), .TXN_ADDR(TXN_ADDR),
    .INIT_AXI_TXN(INIT_AXI_TXN), .TXN_DONE(TXN_DONE), .TXN_ERROR(TXN_ERROR),
    .BUSY(BUSY), .ERR_FLAG(ERR_FLAG), .TIMEOUT_ERR(TIMEOUT_ERR), .WRAP_COUNT(WRAP_COUNT)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [31:0] exp_addr();
    return BASE + 32'((m_bursts % RING_BURSTS) * BURST);
  endfunction

  function automatic int pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_rr + i) % N;
      if (r[k]) return k;
    end
    return 0;
  endfunction

  task automatic model_clear();
    m_bursts = 0;
    m_rr     = 0;
    m_err    = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_addr"}, TXN_ADDR, exp_addr());
    chk({tag, "_wrap"}, WRAP_COUNT, 16'(m_bursts / RING_BURSTS));
    chk({tag, "_err"}, ERR_FLAG, m_err);
    chk({tag, "_busy"}, BUSY, 1'b0);
    chk({tag, "_grant"}, GRANT, '0);
  endtask

  // Called in an IDLE cycle; returns in the IDLE cycle after the burst completes.
  task automatic run_txn(input logic [N-1:0] req, input int lat, input bit err,
                         input bit keep, input bit hold, input bit clr);
    int g;
    g      = pick(req);
    REQ    = req;
    ENABLE = 1'b1;
    step();
    chk("arb_busy", BUSY, 1'b1);
    chk("arb_init", INIT_AXI_TXN, 1'b0);
    step();
    chk("start_init", INIT_AXI_TXN, 1'b1);
    chk("start_grant", GRANT, N'(1) << g);
    chk("start_grant_id", GRANT_ID, g);
    chk("start_addr", TXN_ADDR, exp_addr());
    if (!keep) begin
      REQ    = '0;
      ENABLE = 1'b0;
    end
    step();
    if (clr) CLEAR = 1'b1;
    for (int k = 1; k < lat; k++) begin
      step();
      CLEAR = 1'b0;
    end
    chk("wait_grant", GRANT, N'(1) << g);
    chk("wait_init", INIT_AXI_TXN, 1'b0);
    TXN_DONE  = 1'b1;
    TXN_ERROR = err;
    step();
    CLEAR     = 1'b0;
    TXN_DONE  = 1'b0;
    TXN_ERROR = 1'b0;
    chk("done_ack", DONE_ACK, N'(1) << g);
    chk("done_err", ERR_FLAG, m_err | err);
    chk("done_grant", GRANT, N'(1) << g);
    if (!hold) REQ = '0;
    m_err    = m_err | err;
    m_bursts = m_bursts + 1;
    m_rr     = (g + 1) % N;
    step();
    chk("idle_ack", DONE_ACK, '0);
    check_status("post");
    if (clr) begin
      step();
      model_clear();
      check_status("wclr");
    end
  endtask

  initial begin
    ARESET = 1'b1; ENABLE = 1'b0; CLEAR = 1'b0; REQ = '0; TXN_DONE = 1'b0; TXN_ERROR = 1'b0;
    model_clear();
    step(); step();
    chk("rst_grant", GRANT, '0);
    chk("rst_gid", GRANT_ID, '0);
    chk("rst_ack", DONE_ACK, '0);
    chk("rst_init", INIT_AXI_TXN, 1'b0);
    chk("rst_addr", TXN_ADDR, BASE);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_err", ERR_FLAG, 1'b0);
    chk("rst_to", TIMEOUT_ERR, 1'b0);
    chk("rst_wrap", WRAP_COUNT, '0);
    ARESET = 1'b0;
    step();

    // single requester held, three bursts
    run_txn(4'b0001, 10, 1'b0, 1'b1, 1'b1, 1'b0);
    run_txn(4'b0001, 10, 1'b0, 1'b1, 1'b1, 1'b0);
    run_txn(4'b0001, 10, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("single_addr3", TXN_ADDR, 32'h1000_0C00);

    // CLEAR beats a request in the same IDLE cycle
    CLEAR = 1'b1; REQ = 4'b0001; ENABLE = 1'b1;
    step();
    CLEAR = 1'b0; REQ = '0;
    model_clear();
    check_status("clr_prio");
    step();
    chk("clr_prio_busy2", BUSY, 1'b0);

    // fairness with held requests, wrapping after the fourth burst
    for (int i = 0; i < 6; i++) run_txn(4'b1011, 3, 1'b0, 1'b1, (i != 5), 1'b0);
    chk("fair_wrap", WRAP_COUNT, 16'd1);

    // sticky error, address still advancing
    run_txn(4'b0100, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    run_txn(4'b0100, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    run_txn(4'b0010, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("err_sticky", ERR_FLAG, 1'b1);
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
    model_clear();
    check_status("err_clr");

    // ENABLE low blocks arbitration
    ENABLE = 1'b0; REQ = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dis_busy", BUSY, 1'b0);
    end
    REQ = '0;

    // DONE on the final permitted WAIT cycle beats the timeout
    run_txn(4'b1000, TO, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("edge_to", TIMEOUT_ERR, 1'b0);

    // timeout into HALT
    REQ = 4'b0001; ENABLE = 1'b1;
    step(); step();
    chk("to_init", INIT_AXI_TXN, 1'b1);
    REQ = '0;
    step();
    for (int k = 1; k < TO; k++) step();
    chk("to_last_wait", TIMEOUT_ERR, 1'b0);
    chk("to_last_grant", GRANT, 4'b0001);
    step();
    chk("to_flag", TIMEOUT_ERR, 1'b1);
    chk("to_grant", GRANT, '0);
    chk("to_busy", BUSY, 1'b1);
    chk("to_ack", DONE_ACK, '0);
    chk("to_addr", TXN_ADDR, exp_addr());
    REQ = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_busy", BUSY, 1'b1);
      chk("halt_grant", GRANT, '0);
    end
    REQ = '0; CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
    model_clear();
    check_status("halt_clr");
    chk("halt_clr_to", TIMEOUT_ERR, 1'b0);
    run_txn(4'b0100, 4, 1'b0, 1'b1, 1'b0, 1'b0);

    // CLEAR during WAIT deferred until after DONE
    run_txn(4'b0010, 6, 1'b0, 1'b1, 1'b0, 1'b1);
    run_txn(4'b0001, 1, 1'b0, 1'b0, 1'b0, 1'b1);

    // random traffic
    for (int t = 0; t < 40; t++) begin
      int gap;
      run_txn(4'($urandom_range(1, 15)), $urandom_range(1, TO), ($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)), 1'b0, ($urandom_range(0, 9) == 0));
      gap = $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) begin
        step();
        chk("gap_busy", BUSY, 1'b0);
      end
    end

    // reset mid-WAIT, then a late TXN_DONE
    REQ = 4'b0010; ENABLE = 1'b1;
    step(); step();
    REQ = '0;
    step(); step();
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    chk("mrst_grant", GRANT, '0);
    chk("mrst_gid", GRANT_ID, '0);
    chk("mrst_busy", BUSY, 1'b0);
    chk("mrst_addr", TXN_ADDR, BASE);
    chk("mrst_wrap", WRAP_COUNT, '0);
    chk("mrst_err", ERR_FLAG, 1'b0);
    TXN_DONE = 1'b1;
    step();
    TXN_DONE = 1'b0;
    chk("late_done_ack", DONE_ACK, '0);
    chk("late_done_busy", BUSY, 1'b0);
    step();
    chk("late_done_ack2", DONE_ACK, '0);
    model_clear();
    run_txn(4'b1000, 3, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
